// File: rtl/fc_layer_ctrl_if.sv
// Spike-address input stream and output spike-vector stream of fc_layer_ctrl.
// valid/ready: a beat transfers on the rising edge where both are high; the valid side holds payload stable until then.
interface fc_layer_ctrl_if #(
  parameter int AW         = 6,
  parameter int LAYER_SIZE = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [AW-1:0]         in_addr;
  logic                  in_last;
  logic                  in_empty;
  logic                  out_valid;
  logic                  out_ready;
  logic [LAYER_SIZE-1:0] out_spk;
  logic                  out_last;

  modport master (
    output in_valid, in_addr, in_last, in_empty, out_ready,
    input  in_ready, out_valid, out_spk, out_last
  );

  modport slave (
    input  in_valid, in_addr, in_last, in_empty, out_ready,
    output in_ready, out_valid, out_spk, out_last
  );
endinterface

// File: rtl/fc_layer_ctrl.sv
// Time-step sequencer for a bank of fully-connected neuron cores: buffers one
// step of spike addresses, replays them as a framed burst, collects the spikes.
module fc_layer_ctrl #(
  parameter int IN_CHANNELS      = 2,
  parameter int INPUT_FRAME_SIZE = 28,
  parameter int LAYER_SIZE       = 10,
  parameter int NUM_STEPS        = 25,
  localparam int DEPTH           = IN_CHANNELS * INPUT_FRAME_SIZE,
  localparam int AW              = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  fc_layer_ctrl_if.slave        bus,
  input  logic                  start,
  output logic                  en_accum,
  output logic [AW-1:0]         spk_addr,
  output logic                  en_activ,
  output logic                  last_time_step,
  input  logic [LAYER_SIZE-1:0] nc_spk,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [3:0]            dbg_state
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FILL, S_START, S_PLAY, S_DRAIN, S_ACTIV, S_WAIT, S_CAPT, S_OUT
  } state_t;

  state_t        state;
  logic [AW-1:0] mem [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] rp;
  logic [SW-1:0] step;
  logic          accept;
  logic          wr_en;
  logic          fill_full;
  logic          last_step;

  assign accept    = (state == S_FILL) && bus.in_valid && bus.in_ready;
  assign wr_en     = accept && !bus.in_empty;
  assign fill_full = wr_en && !bus.in_last && (cnt == CW'(DEPTH - 1));
  assign last_step = (step == SW'(NUM_STEPS - 1));
  assign dbg_state = state;

  // Buffer has no reset; only the first cnt entries are ever read back.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt[AW-1:0]] <= bus.in_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      rp             <= '0;
      step           <= '0;
      bus.in_ready   <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_spk    <= '0;
      bus.out_last   <= 1'b0;
      en_accum       <= 1'b0;
      en_activ       <= 1'b0;
      last_time_step <= 1'b0;
      spk_addr       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      en_accum       <= 1'b0;
      en_activ       <= 1'b0;
      last_time_step <= 1'b0;
      done           <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_FILL;
            step         <= '0;
            cnt          <= '0;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
          end
        end
        S_FILL: begin
          if (accept) begin
            if (wr_en) cnt <= cnt + 1'b1;
            // A full buffer closes the step early; the rest spills into the next step.
            if (bus.in_last || fill_full) begin
              state        <= S_START;
              bus.in_ready <= 1'b0;
              en_accum     <= 1'b1;
            end
            if (fill_full) ovf <= 1'b1;
          end
        end
        S_START: begin
          if (cnt == '0) begin
            state          <= S_ACTIV;
            en_activ       <= 1'b1;
            last_time_step <= last_step;
          end else begin
            state    <= S_PLAY;
            spk_addr <= mem[0];
            rp       <= CW'(1);
          end
        end
        S_PLAY: begin
          if (rp == cnt) begin
            state <= S_DRAIN;
          end else begin
            spk_addr <= mem[rp[AW-1:0]];
            rp       <= rp + 1'b1;
          end
        end
        S_DRAIN: begin
          state          <= S_ACTIV;
          spk_addr       <= '0;
          en_activ       <= 1'b1;
          last_time_step <= last_step;
        end
        S_ACTIV: state <= S_WAIT;
        S_WAIT:  state <= S_CAPT;
        S_CAPT: begin
          state         <= S_OUT;
          bus.out_spk   <= nc_spk;
          bus.out_last  <= last_step;
          bus.out_valid <= 1'b1;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            if (last_step) begin
              state <= S_IDLE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state        <= S_FILL;
              step         <= step + 1'b1;
              cnt          <= '0;
              bus.in_ready <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl: directed inferences plus randomized steps, checked
// against a step-segmentation model built from queues of input beats.
module tb_fc_layer_ctrl;
  localparam int IN_CHANNELS      = 2;
  localparam int INPUT_FRAME_SIZE = 28;
  localparam int LAYER_SIZE       = 10;
  localparam int NUM_STEPS        = 2;
  localparam int DEPTH            = IN_CHANNELS * INPUT_FRAME_SIZE;
  localparam int AW               = $clog2(DEPTH);

  typedef struct {
    logic [AW-1:0] addr;
    logic          last;
    logic          empty;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  en_accum;
  logic [AW-1:0]         spk_addr;
  logic                  en_activ;
  logic                  last_time_step;
  logic [LAYER_SIZE-1:0] nc_spk;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic [3:0]            dbg_state;

  fc_layer_ctrl_if #(.AW(AW), .LAYER_SIZE(LAYER_SIZE)) bus ();

  fc_layer_ctrl #(
    .IN_CHANNELS(IN_CHANNELS), .INPUT_FRAME_SIZE(INPUT_FRAME_SIZE),
    .LAYER_SIZE(LAYER_SIZE), .NUM_STEPS(NUM_STEPS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start),
    .en_accum(en_accum), .spk_addr(spk_addr), .en_activ(en_activ),
    .last_time_step(last_time_step), .nc_spk(nc_spk), .busy(busy),
    .done(done), .ovf(ovf), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  beat_t feed[$];
  beat_t cur[$];
  logic [AW-1:0] exp_q[$];
  logic ovf_exp = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {bus.in_ready, en_accum, en_activ, last_time_step, spk_addr,
                bus.out_valid, bus.out_spk, bus.out_last, busy, done, ovf, dbg_state}, 64'd0);
  endtask

  task automatic push_beat(input logic [AW-1:0] a, input logic l, input logic e);
    beat_t b;
    b.addr = a; b.last = l; b.empty = e;
    feed.push_back(b);
  endtask

  task automatic push_random_step(input int n);
    if (n == 0) push_beat('0, 1'b1, 1'b1);
    for (int i = 0; i < n; i++)
      push_beat(AW'($urandom_range(0, DEPTH - 1)), (i == n - 1), 1'b0);
  endtask

  // Reference model: a step closes on in_last or once DEPTH addresses are held.
  task automatic next_step(output logic ended_by_fill);
    int wr;
    beat_t b;
    wr = 0;
    ended_by_fill = 1'b0;
    cur.delete();
    exp_q.delete();
    while (feed.size() > 0) begin
      b = feed.pop_front();
      cur.push_back(b);
      if (!b.empty) begin
        exp_q.push_back(b.addr);
        wr++;
      end
      if (b.last) break;
      if (wr == DEPTH) begin
        ended_by_fill = 1'b1;
        break;
      end
    end
  endtask

  // Driver: starts and ends just after a falling edge.
  task automatic send_beat(input beat_t b, input bit gaps);
    int waitc;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_addr  = AW'($urandom_range(0, DEPTH - 1));
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b1;
    bus.in_addr  = b.addr;
    bus.in_last  = b.last;
    bus.in_empty = b.empty;
    waitc = 0;
    while (!bus.in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_wait", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_empty = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_step(input int sidx, input logic [LAYER_SIZE-1:0] vec,
                          input int hold, input bit gaps);
    logic fill_end;
    logic [AW-1:0] a;
    logic [AW-1:0] last_a;
    int n;
    next_step(fill_end);
    if (fill_end) ovf_exp = 1'b1;
    n = exp_q.size();
    last_a = '0;
    check("fill_in_ready", bus.in_ready, 1);
    foreach (cur[i]) send_beat(cur[i], gaps);
    check("en_accum", en_accum, 1);
    check("accum_no_activ", en_activ, 0);
    check("accum_in_ready", bus.in_ready, 0);
    check("accum_spk_addr", spk_addr, 0);
    bus.in_valid = 1'b1;
    bus.in_addr  = AW'($urandom_range(0, DEPTH - 1));
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a = exp_q.pop_front();
      last_a = a;
      check("spk_addr", spk_addr, a);
      check("play_strobes", {en_accum, en_activ}, 0);
      check("play_in_ready", bus.in_ready, 0);
    end
    if (n > 0) begin
      @(negedge clk);
      check("drain_addr", spk_addr, last_a);
      check("drain_strobes", {en_accum, en_activ}, 0);
    end
    @(negedge clk);
    check("en_activ", en_activ, 1);
    check("activ_no_accum", en_accum, 0);
    check("last_time_step", last_time_step, sidx == NUM_STEPS - 1);
    check("activ_spk_addr", spk_addr, 0);
    nc_spk = LAYER_SIZE'($urandom);
    @(negedge clk);
    check("activ_pulse", {en_activ, last_time_step}, 0);
    nc_spk = ~vec;
    @(negedge clk);
    check("out_valid_early", bus.out_valid, 0);
    nc_spk = vec;
    @(negedge clk);
    nc_spk = ~vec;
    bus.in_valid = 1'b0;
    check("out_valid", bus.out_valid, 1);
    check("out_spk", bus.out_spk, vec);
    check("out_last", bus.out_last, sidx == NUM_STEPS - 1);
    check("ovf", ovf, ovf_exp);
    check("out_busy", busy, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_spk", bus.out_spk, vec);
      check("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("accept_out_valid", bus.out_valid, 0);
    if (sidx == NUM_STEPS - 1) begin
      check("done", done, 1);
      check("done_busy", busy, 0);
      check("done_in_ready", bus.in_ready, 0);
      @(negedge clk);
      check("done_pulse", done, 0);
    end else begin
      check("next_in_ready", bus.in_ready, 1);
      check("next_no_done", done, 0);
    end
  endtask

  task automatic run_inference(input bit gaps);
    do_start();
    for (int s = 0; s < NUM_STEPS; s++)
      run_step(s, LAYER_SIZE'($urandom), $urandom_range(0, 4), gaps);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; nc_spk = '0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_last = 1'b0;
    bus.in_empty = 1'b0; bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1 check_all_zero("reset_state");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // Directed three-spike step then single-spike step, with back-pressure.
    push_beat(AW'(3), 1'b0, 1'b0);
    push_beat(AW'(7), 1'b0, 1'b0);
    push_beat(AW'(12), 1'b1, 1'b0);
    push_beat(AW'(0), 1'b1, 1'b0);
    do_start();
    run_step(0, 10'b1000000101, 20, 1'b0);
    run_step(1, LAYER_SIZE'($urandom), 3, 1'b0);

    // Zero-spike step followed by a short randomly gapped step.
    push_random_step(0);
    push_random_step($urandom_range(1, 5));
    run_inference(1'b1);

    // Full frame closed by in_last on the final beat.
    for (int i = 0; i < DEPTH; i++)
      push_beat(AW'((i * 13) % DEPTH), (i == DEPTH - 1), 1'b0);
    push_random_step(0);
    run_inference(1'b0);

    // Full frame without in_last: forced replay, remainder lands in the next step.
    for (int i = 0; i < DEPTH; i++) push_beat(AW'($urandom_range(0, DEPTH - 1)), 1'b0, 1'b0);
    push_random_step(3);
    run_inference(1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NUM_STEPS; s++) push_random_step($urandom_range(0, 8));
      run_inference(1'b1);
    end

    // Reset in the middle of a replay burst.
    push_random_step(20);
    do_start();
    next_step(ovf_exp);
    foreach (cur[i]) send_beat(cur[i], 1'b0);
    repeat (5) @(negedge clk);
    check("mid_play_addr", spk_addr, cur[4].addr);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_mid_play");
    @(negedge clk);
    rst = 1'b0;
    ovf_exp = 1'b0;
    for (int s = 0; s < NUM_STEPS; s++) push_random_step($urandom_range(1, 6));
    run_inference(1'b1);

    // Reset while an output vector is being offered.
    push_random_step(0);
    do_start();
    next_step(ovf_exp);
    foreach (cur[i]) send_beat(cur[i], 1'b0);
    repeat (4) @(negedge clk);
    check("pre_reset_out_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_in_out");
    @(negedge clk);
    rst = 1'b0;
    ovf_exp = 1'b0;
    for (int s = 0; s < NUM_STEPS; s++) push_random_step($urandom_range(0, 6));
    run_inference(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
